seq_multiplier: RTL

- Parametrised iterative radix-2 shift-add multiplier; successor to the fixed 8x8 combinational array multiplier.
- Takes WIDTH x WIDTH operands and returns a 2*WIDTH product. Supports unsigned and two's-complement signed operands, selected per operation.
- Ready/valid handshakes on both sides let it sit between pipelined datapath stages in place of the combinational array when area matters more than latency.

---
 rtl/seq_multiplier.sv | 106 ++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Unsigned or two's-complement signed operands are selected per operation.
// Ready/valid handshakes are used on both the operand side and the product side.
// Optional build macro SEQ_MUL_EARLY_TERM_EN: CALC also finishes as soon as no
// multiplier bits remain, which gives data-dependent latency.
module seq_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplr;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic                 neg;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     mplr_next;
    logic                 last;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Operand magnitudes, the next partial sum, and the finish condition for the current step
    always_comb begin
        mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
        mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
        acc_next  = acc + (mplr[0] ? mcand : '0);
        mplr_next = mplr >> 1;
`ifdef SEQ_MUL_EARLY_TERM_EN
        last      = (cnt == CNT_W'(1)) || (mplr_next == '0);
`else
        last      = (cnt == CNT_W'(1));
`endif
    end

    // Control FSM and datapath registers; product and out_valid are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mcand     <= '0;
            mplr      <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= {{WIDTH{1'b0}}, mag_a};
                        mplr  <= mag_b;
                        acc   <= '0;
                        cnt   <= CNT_W'(WIDTH);
                        neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    mplr  <= mplr_next;
                    cnt   <= cnt - CNT_W'(1);
                    if (last) begin
                        product   <= neg ? -acc_next : acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
